// File: rtl/i2s_pkg.sv
// Shared constants, types and helpers for the I2S transmitter.
//   SAMPLE_W   bits per channel slot
//   FRAME_BITS bits per stereo frame (BCLK cycles per LRCK period)
//   CNT_W      width of the bit-position counter
//   stereo_t   one stereo PCM frame, left channel in the upper half
//   lrck_of(n) word-select level for frame bit position n (Philips timing)
package i2s_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 2 * SAMPLE_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

  // LRCK switches one BCLK ahead of each slot's MSB: high from the left LSB
  // position through the position before the right LSB.
  function automatic logic lrck_of(input logic [CNT_W-1:0] n);
    return (n >= CNT_W'(SAMPLE_W - 1)) && (n <= CNT_W'(FRAME_BITS - 2));
  endfunction

endpackage

// File: rtl/i2s_tx_nco_nco.sv
// Fractional phase accumulator producing the BCLK edge tick.
//   clk        system clock
//   rst        synchronous active-high reset
//   en         1 = accumulate, 0 = accumulator and tick held at 0
//   phase_inc  step per clk; clamped to half scale
//   tick       registered carry; one pulse per BCLK edge
module i2s_nco #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] phase_inc,
  output logic             tick
);

  // Half scale guarantees at most one carry every two clocks.
  localparam logic [ACC_W-1:0] INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc_q, acc_d, inc_eff;
  logic             carry_d;
  logic             tick_q;

  always_comb begin
    inc_eff            = (phase_inc > INC_MAX) ? INC_MAX : phase_inc;
    {carry_d, acc_d}   = {1'b0, acc_q} + {1'b0, inc_eff};
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= carry_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/i2s_tx_nco.sv
// Philips-format I2S transmitter with an NCO-derived bit clock.
//   clk, rst      system clock, synchronous active-high reset
//   en            1 = run the serial output, 0 = outputs quiet
//   phase_inc     NCO step; tick rate = f_clk*phase_inc/2^ACC_W = 2*f_BCLK
//   s_valid/s_ready, s_left/s_right   stereo sample handshake
//   i2s_bclk, i2s_lrck, i2s_sdata     serial interface to the DAC
//   frame_start   1-clk pulse when a frame loads into the shifter
//   underrun      1-clk pulse when that load found the holding register empty
//   underrun_cnt  saturating count of underruns
module i2s_tx_nco
  import i2s_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [ACC_W-1:0]    phase_inc,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                s_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sdata,
  output logic                frame_start,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

  logic                  tick;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, n_next;
  logic [FRAME_BITS-1:0] shifter_q, shifter_d, frame_src;
  stereo_t               hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  ready_en_q;
  logic                  bclk_q, bclk_d, lrck_q, lrck_d, sdata_q, sdata_d;
  logic                  fs_q, fs_d, ur_q, ur_d;
  logic [15:0]           underrun_cnt_q, underrun_cnt_d;
  logic                  accept;

  i2s_nco #(.ACC_W(ACC_W)) u_nco (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .phase_inc (phase_inc),
    .tick      (tick)
  );

  // ready_en_q keeps s_ready low through reset and for the first clock after.
  assign s_ready = ready_en_q && !hold_full_q;
  assign accept  = s_valid && s_ready;
  assign n_next  = (bit_cnt_q == LAST) ? '0 : bit_cnt_q + CNT_W'(1);

  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    shifter_d      = shifter_q;
    hold_d         = hold_q;
    hold_full_d    = hold_full_q;
    bclk_d         = bclk_q;
    lrck_d         = lrck_q;
    sdata_d        = sdata_q;
    underrun_cnt_d = underrun_cnt_q;
    fs_d           = 1'b0;
    ur_d           = 1'b0;
    frame_src      = shifter_q;

    // Accept and load are exclusive: accept needs an empty hold, load
    // only clears a full one.
    if (accept) begin
      hold_d.left  = s_left;
      hold_d.right = s_right;
      hold_full_d  = 1'b1;
    end

    if (!en) begin
      bclk_d    = 1'b0;
      lrck_d    = 1'b0;
      sdata_d   = 1'b0;
      bit_cnt_d = LAST;
    end else if (tick) begin
      bclk_d = !bclk_q;
      // Only the falling BCLK edge moves data; the rising edge is the DAC's.
      if (bclk_q) begin
        bit_cnt_d = n_next;
        lrck_d    = lrck_of(n_next);
        if (n_next == '0) begin
          fs_d = 1'b1;
          if (hold_full_q) begin
            frame_src   = hold_q;
            hold_full_d = 1'b0;
          end else begin
            frame_src = '0;
            ur_d      = 1'b1;
            if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
          end
        end
        sdata_d   = frame_src[FRAME_BITS-1];
        shifter_d = {frame_src[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q      <= LAST;
      shifter_q      <= '0;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      ready_en_q     <= 1'b0;
      bclk_q         <= 1'b0;
      lrck_q         <= 1'b0;
      sdata_q        <= 1'b0;
      fs_q           <= 1'b0;
      ur_q           <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      bit_cnt_q      <= bit_cnt_d;
      shifter_q      <= shifter_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      ready_en_q     <= 1'b1;
      bclk_q         <= bclk_d;
      lrck_q         <= lrck_d;
      sdata_q        <= sdata_d;
      fs_q           <= fs_d;
      ur_q           <= ur_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign i2s_bclk     = bclk_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_sdata    = sdata_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_tx_nco.sv
// Testbench for i2s_tx_nco: directed sequence with random sample data,
// scored against a frame-level model of the I2S stream.
module tb_i2s_tx_nco;
  import i2s_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, s_valid;
  logic [23:0] phase_inc;
  logic [15:0] s_left, s_right;
  logic        s_ready, i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun;
  logic [15:0] underrun_cnt;

  always #5 clk = ~clk;

  i2s_tx_nco #(.ACC_W(24)) dut (
    .clk(clk), .rst(rst), .en(en), .phase_inc(phase_inc),
    .s_valid(s_valid), .s_left(s_left), .s_right(s_right), .s_ready(s_ready),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
    .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] src_q[$];   // samples waiting to be offered
  logic [31:0] exp_q[$];   // accepted, not yet played
  bit          feed     = 0;
  bit          in_frame = 0;
  int          bitpos   = 0;
  logic [31:0] cur_frame = '0;
  int          model_cnt = 0;
  logic        prev_bclk = 1'b0;
  int          toggles  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: observed no event expected event", tag);
  endtask

  task automatic drive();
    s_valid = feed && (src_q.size() > 0);
    if (src_q.size() > 0) {s_left, s_right} = src_q[0];
  endtask

  // One clock: apply the model to what the DUT did on this edge.
  task automatic step();
    bit took, en_pre, rst_pre;
    took    = s_valid && s_ready && !rst;
    en_pre  = en;
    rst_pre = rst;
    @(posedge clk);
    #1;
    if (rst_pre) begin
      exp_q.delete();
      model_cnt = 0;
      in_frame  = 0;
    end else begin
      if (!en_pre) in_frame = 0;
      if (frame_start) begin
        chk("underrun_at_load", underrun, exp_q.size() == 0);
        if (exp_q.size() == 0) begin
          cur_frame = '0;
          if (model_cnt < 65535) model_cnt++;
        end else begin
          cur_frame = exp_q.pop_front();
        end
        in_frame = 1;
        bitpos   = 0;
      end else begin
        chk("underrun_without_load", underrun, 1'b0);
      end
      if (took) exp_q.push_back(src_q.pop_front());
      if (prev_bclk === 1'b0 && i2s_bclk === 1'b1 && in_frame) begin
        chk("bit_in_frame", bitpos < 32, 1'b1);
        if (bitpos < 32) begin
          chk("sdata", i2s_sdata, cur_frame[31-bitpos]);
          chk("lrck", i2s_lrck, ((bitpos + 1) % 32) >= 16);
        end
        bitpos++;
      end
    end
    chk("underrun_cnt", underrun_cnt, 32'(model_cnt));
    if (i2s_bclk !== prev_bclk) toggles++;
    prev_bclk = i2s_bclk;
    drive();
  endtask

  task automatic wait_fs(input int limit, output int clks);
    clks = 0;
    do begin
      step();
      clks++;
    end while (!frame_start && clks < limit);
    if (!frame_start) fail_now("wait_frame_start");
  endtask

  task automatic wait_bit(input int pos, input int limit);
    int k;
    k = 0;
    while (!(in_frame && bitpos == pos) && k < limit) begin
      step();
      k++;
    end
    if (!(in_frame && bitpos == pos)) fail_now("wait_bit_position");
  endtask

  initial begin
    int     c;
    logic   b;
    longint exp_t;

    rst = 1'b1; en = 1'b0; phase_inc = '0;
    s_valid = 1'b0; s_left = '0; s_right = '0;

    // Reset state
    repeat (3) step();
    chk("rst_bclk", i2s_bclk, 0);
    chk("rst_lrck", i2s_lrck, 0);
    chk("rst_sdata", i2s_sdata, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_underrun_cnt", underrun_cnt, 0);
    rst = 1'b0;
    step();
    chk("s_ready_after_rst", s_ready, 1);

    // Prefill, then timing at half-scale step and bit order
    src_q.push_back({16'hA5C3, 16'h0F01});
    repeat (3) src_q.push_back($urandom);
    feed = 1;
    drive();
    step();
    step();
    chk("s_ready_when_full", s_ready, 0);
    en = 1'b1;
    phase_inc = 24'h800000;
    wait_fs(400, c);
    for (int k = 1; k < 128; k++) begin
      step();
      chk("bclk_pattern", i2s_bclk, (k >> 1) & 1);
      chk("no_early_frame_start", frame_start, 0);
    end
    step();
    chk("frame_period_128", frame_start, 1);

    // Backpressure: continuous valid, counting sequence
    for (int i = 1; i <= 8; i++) src_q.push_back({16'(2*i-1), 16'(2*i)});
    for (int i = 0; i < 8; i++) begin
      wait_fs(200, c);
      chk("ready_high_after_load", s_ready, 1);
      step();
      chk("ready_low_after_accept", s_ready, 0);
    end

    // Underrun: stop supplying
    feed = 0;
    drive();
    chk("cnt_before_underrun", underrun_cnt, 0);
    c = 0;
    for (int i = 0; i < 8 && model_cnt < 3; i++) wait_fs(200, c);
    chk("underrun_cnt_3", underrun_cnt, 3);
    wait_fs(200, c);
    chk("underrun_silent_frame", exp_q.size() == 0 && cur_frame == 0, 1);

    // Saturation from a preloaded count
    force dut.underrun_cnt_q = 16'hFFFE;
    model_cnt = 65534;
    step();
    release dut.underrun_cnt_q;
    wait_fs(200, c);
    chk("underrun_cnt_to_max", underrun_cnt, 16'hFFFF);
    wait_fs(200, c);
    chk("underrun_cnt_saturated", underrun_cnt, 16'hFFFF);

    // Step above half scale is clamped: one toggle per 2 clks
    phase_inc = 24'hFFFFFF;
    step();
    toggles = 0;
    repeat (400) step();
    chk("clamp_toggles", (toggles >= 199 && toggles <= 201), 1);

    // Fractional rate
    phase_inc = 24'd1315334;
    step();
    toggles = 0;
    repeat (40000) step();
    exp_t = (longint'(40000) * 1315334) >>> 24;
    chk("fractional_ticks", (toggles >= exp_t - 1 && toggles <= exp_t + 1), 1);

    // Zero step: bclk frozen
    phase_inc = '0;
    step();
    step();
    b = i2s_bclk;
    toggles = 0;
    repeat (200) step();
    chk("zero_inc_toggles", toggles, 0);
    chk("zero_inc_bclk", i2s_bclk, b);

    // en dropped mid-left-slot
    phase_inc = 24'h800000;
    repeat (4) src_q.push_back($urandom);
    feed = 1;
    drive();
    wait_fs(400, c);
    wait_bit(9, 200);
    en = 1'b0;
    step();
    chk("en_off_outputs", {i2s_bclk, i2s_lrck, i2s_sdata}, 0);
    repeat (20) begin
      step();
      chk("en_off_quiet", {i2s_bclk, i2s_lrck, i2s_sdata}, 0);
    end
    chk("en_off_hold_kept", s_ready, 0);
    en = 1'b1;
    wait_fs(400, c);
    chk("reenable_no_underrun", underrun, 0);
    chk("reenable_lrck", i2s_lrck, 0);
    chk("reenable_msb", i2s_sdata, cur_frame[31]);
    wait_bit(32, 200);

    // rst pulsed mid-left-slot
    wait_fs(400, c);
    wait_bit(9, 200);
    rst = 1'b1;
    step();
    chk("rst_mid_outputs", {i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun}, 0);
    chk("rst_mid_s_ready", s_ready, 0);
    chk("rst_mid_cnt", underrun_cnt, 0);
    step();
    chk("rst_mid_s_ready_2", s_ready, 0);
    rst = 1'b0;
    step();
    chk("rst_mid_ready_return", s_ready, 1);
    wait_fs(400, c);
    chk("after_rst_no_underrun", underrun, 0);
    chk("after_rst_lrck", i2s_lrck, 0);
    chk("after_rst_msb", i2s_sdata, cur_frame[31]);
    wait_bit(32, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_nco.md
Name: i2s_tx_nco

Overview:
- Audio-output end of the clock chain: takes the PLL-derived system clock (36 MHz CLKOUTD domain) and produces Philips-format I2S (BCLK, LRCK, SDATA) for the external DAC.
- BCLK comes from a fractional phase accumulator, so non-integer ratios work (36 MHz to 1.4112 MHz for 44.1 kHz x 32 bits).
- Accepts stereo PCM frames from the decoder/packet path over a valid/ready handshake.
- Single-frame holding buffer; underruns are counted.

Parameters:
- SAMPLE_W, 16, bits per channel slot; frame is 2*SAMPLE_W BCLK cycles.
- ACC_W, 24, phase accumulator width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = run I2S output, 0 = idle and quiet.
- phase_inc  in  ACC_W  accumulator step per clk. Tick rate = f_clk*phase_inc/2^ACC_W = 2*f_BCLK.
- s_valid  in  1  stereo sample present.
- s_left  in  SAMPLE_W  left sample, two's complement.
- s_right  in  SAMPLE_W  right sample.
- s_ready  out  1  holding register empty.
- i2s_bclk  out  1  bit clock.
- i2s_lrck  out  1  word select (0 = left).
- i2s_sdata  out  1  serial data, MSB first.
- frame_start  out  1  1-clk pulse when a frame loads into the shifter.
- underrun  out  1  1-clk pulse when a frame loads with the holding register empty.
- underrun_cnt  out  16  saturating count of underruns.

Behaviour:
- Reset:
  - acc=0, bclk=0, lrck=0, sdata=0, s_ready=0, frame_start=0, underrun=0, underrun_cnt=0, hold_full=0.
  - bit_cnt = 2*SAMPLE_W-1.
  - s_ready goes to 1 on the first clk after rst deasserts.
- NCO:
  - Each clk while en=1: {carry,acc} <= acc + inc_eff, where inc_eff = min(phase_inc, 2^(ACC_W-1)).
  - tick = carry, registered. So at most one tick every 2 clks; BCLK period is at least 4 clks.
  - phase_inc=0: no ticks, all outputs hold.
- Each tick toggles bclk:
  - 0->1 is the rise event (DAC samples); no other action.
  - 1->0 is the fall event.
- On each fall event:
  - n = (bit_cnt == 2W-1) ? 0 : bit_cnt+1; bit_cnt <= n.
  - sdata <= shifter[2W-1]; shifter shifts left with 0 fill.
  - lrck <= 1 if W-1 <= n <= 2W-2, else 0. LRCK therefore leads the MSB by one BCLK (Philips).
- Frame load: on the fall event where n=0, before the shift:
  - hold_full=1: shifter <= {hold_l, hold_r}; hold_full <= 0; frame_start=1.
  - hold_full=0: shifter <= 0; underrun=1; frame_start=1; underrun_cnt += 1, saturating at 0xFFFF.
  - sdata in that same cycle carries the loaded frame's bit 2W-1 (left MSB).
- Handshake:
  - s_ready = !hold_full.
  - Accept on s_valid && s_ready: hold <= {s_left, s_right}, hold_full <= 1.
  - A load and an accept cannot occur in the same clk because ready is 0 while full.
  - A new accept is possible from the clk after a load.
  - s_valid with s_ready=0 is held off; inputs must stay stable until accepted.
- en:
  - en=0: acc, bclk, lrck, sdata forced to 0 and bit_cnt forced to 2W-1 within 1 clk. The handshake and holding register stay active.
  - en 0->1: the first fall event loads a frame, so a prefilled hold gives no underrun.
  - Deasserting en mid-frame discards the remaining bits of that frame.
- rst mid-frame: full reset state as above; hold contents are discarded.
- phase_inc change: takes effect on the next clk; bclk toggles stay glitch-free (toggle only).

Decomposition:
- Package i2s_pkg:
  - constants SAMPLE_W and FRAME_BITS = 2*SAMPLE_W;
  - typedef stereo_t = struct {left, right};
  - function lrck_of(n).
- One sub-module: i2s_nco (ACC_W) with inputs clk, rst, en, phase_inc and output tick. It contains the accumulator, clamp and registered carry.

Test Plan:
- Timing at phase_inc=2^23, W=16, en=1, hold preloaded:
  - stimulus: run one frame;
  - response: tick every 2 clks; BCLK period 4 clks; frame = 128 clks; one frame_start per 128 clks.
- Bit order: push L=0xA5C3, R=0x0F01 -> sampled on BCLK rising edges, sdata gives bits 15..0 of 0xA5C3 with lrck=0, then 0x0F01 with lrck=1. LRCK rises 1 BCLK before the R MSB and falls 1 BCLK before the next L MSB.
- Underrun: stop s_valid after 2 frames -> third frame outputs all zeros; underrun pulses once per frame; underrun_cnt reaches 3 after 3 empty frames and stays at 0xFFFF once saturated (force-preload test).
- Backpressure: hold s_valid=1 continuously -> s_ready is 1 for exactly 1 clk after each frame_start; no sample is lost or duplicated over 8 frames (compare against a sequence 0x0001..0x0010).
- Fractional rate at phase_inc=1315334, 1,000,000 clks:
  - required tick count = 78,400 +/- 1;
  - zero phase_inc: bclk static.
- Mid-frame disruption: drop en at bit 9 of the left slot, re-enable 20 clks later -> outputs go 0 within 1 clk; the first frame after re-enable starts with lrck=0 and the held sample's MSB. The same check is repeated with rst pulsed instead of en: outputs take reset values and s_ready=0 during rst.
